tetris_ctrl: RTL and testbench

Command sequencer feeding the `tetris` core's `ctrl` and `bar_mask` inputs. It merges debounced push-buttons, UART keystrokes, a score-dependent gravity timer and a periodic garbage-bar generator into single-cycle `state_type` commands. Commands are issued only when the core can accept them: `game_state` is WAIT, INIT or END.

---
 rtl/tetris_ctrl.sv | 120 ++++++++++++
 tb/tb_tetris_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/tetris_ctrl.sv
// tetris_ctrl: merges buttons, UART keys, gravity and garbage bars into single-cycle core commands.
package tetris_pkg;
   typedef enum logic [3:0] {
      NONE, LEFT, RIGHT, ROTATE, ROTATE_REV, DOWN, DROP, HOLD, BAR,
      INIT, WAIT, MOVE, CLEAR, END
   } state_type;
endpackage

module tetris_ctrl
   import tetris_pkg::*;
#(
   parameter int unsigned GRAVITY_BASE  = 100_000_000,
   parameter int unsigned GRAVITY_STEP  = 6_000_000,
   parameter int unsigned GRAVITY_MIN   = 10_000_000,
   parameter int unsigned REPEAT_DELAY  = 30_000_000,
   parameter int unsigned REPEAT_PERIOD = 8_000_000,
   parameter int unsigned BAR_PERIOD    = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  btn,
   input  logic        uart_valid,
   input  logic [7:0]  uart_data,
   input  state_type   game_state,
   input  logic [15:0] score,
   output state_type   ctrl,
   output logic [9:0]  bar_mask
);
   state_type   fifo [4];
   state_type   ucmd, bcmd;
   logic [1:0]  wp, rp;
   logic [2:0]  cnt;
   logic [3:0]  btn_q, pend, rarm, rise, rhit, bsel, lvl;
   logic [31:0] rcnt [4];
   logic [31:0] gcnt, bcnt, prod, period;
   logic [7:0]  lfsr, hole;
   logic        grav_pend, bar_pend, is_wait, is_idle, active, empty, full;
   logic        pop, take_bar, take_grav, can_wr, uwr, bwr, grav_hit, bar_hit;
   logic        unused;

   always_comb begin
      case (uart_data)
         "a":     ucmd = LEFT;
         "d":     ucmd = RIGHT;
         "w":     ucmd = ROTATE;
         "q":     ucmd = ROTATE_REV;
         "s":     ucmd = DOWN;
         " ":     ucmd = DROP;
         "c":     ucmd = HOLD;
         default: ucmd = NONE;
      endcase
   end

   assign is_wait   = game_state == WAIT;
   assign is_idle   = game_state == INIT || game_state == END;
   assign active    = !is_idle;
   assign empty     = cnt == 3'd0;
   assign full      = cnt == 3'd4;
   assign take_bar  = !reset && is_wait && bar_pend;
   assign take_grav = !reset && is_wait && !bar_pend && grav_pend;
   assign pop       = !reset && !empty && (is_idle || (is_wait && !bar_pend && !grav_pend));
   // In INIT/END any queued key starts the game, so the head is replaced by DOWN.
   assign ctrl      = take_bar ? BAR : take_grav ? DOWN : !pop ? NONE : is_idle ? DOWN : fifo[rp];

   assign can_wr = !full || pop;
   assign uwr    = uart_valid && ucmd != NONE && can_wr;
   assign bwr    = |pend && !uwr && can_wr;
   assign bsel   = pend[0] ? 4'b0001 : pend[1] ? 4'b0010 : pend[2] ? 4'b0100 : 4'b1000;
   assign bcmd   = pend[0] ? LEFT : pend[1] ? RIGHT : pend[2] ? ROTATE : DOWN;
   assign rise   = btn & ~btn_q;

   always_comb
      for (int i = 0; i < 4; i++)
         rhit[i] = btn[i] && btn_q[i] && rcnt[i] >= (rarm[i] ? REPEAT_PERIOD : REPEAT_DELAY) - 32'd1;

   assign lvl      = score[15:8] == 8'd0 ? score[7:4] : 4'd15;
   assign prod     = 32'(lvl) * GRAVITY_STEP;
   assign period   = (GRAVITY_BASE > prod && GRAVITY_BASE - prod > GRAVITY_MIN) ? GRAVITY_BASE - prod : GRAVITY_MIN;
   assign grav_hit = gcnt >= period - 32'd1;
   assign bar_hit  = BAR_PERIOD != 0 && bcnt >= BAR_PERIOD - 32'd1;
   assign hole     = lfsr % 8'd10;
   assign unused   = ^{score[3:0], hole[7:4]};

   always_ff @(posedge clk) begin
      if (reset) begin
         wp        <= '0;
         rp        <= '0;
         cnt       <= '0;
         btn_q     <= '0;
         pend      <= '0;
         rarm      <= '0;
         gcnt      <= '0;
         bcnt      <= '0;
         grav_pend <= 1'b0;
         bar_pend  <= 1'b0;
         lfsr      <= 8'h01;
         bar_mask  <= 10'h3FD;
         for (int i = 0; i < 4; i++) rcnt[i] <= '0;
      end else begin
         if (uwr || bwr) begin
            fifo[wp] <= uwr ? ucmd : bcmd;
            wp       <= wp + 2'd1;
         end
         if (pop) rp <= rp + 2'd1;
         cnt   <= cnt + 3'(uwr || bwr) - 3'(pop);
         btn_q <= btn;
         pend  <= (pend & ~(bwr ? bsel : 4'd0)) | rise | rhit;
         for (int i = 0; i < 4; i++) begin
            rcnt[i] <= (!btn[i] || !btn_q[i] || rhit[i]) ? 32'd0 : rcnt[i] + 32'd1;
            rarm[i] <= btn[i] && (rarm[i] || rhit[i]);
         end
         gcnt      <= (!active || grav_hit) ? 32'd0 : gcnt + 32'd1;
         grav_pend <= active && ((grav_pend && !take_grav) || grav_hit);
         bcnt      <= (!active || bar_hit || BAR_PERIOD == 0) ? 32'd0 : bcnt + 32'd1;
         bar_pend  <= active && ((bar_pend && !take_bar) || bar_hit);
         if (take_bar) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         bar_mask <= ~(10'd1 << hole[3:0]);
      end
   end
endmodule

// File: tb/tb_tetris_ctrl.sv
// tb_tetris_ctrl: table-driven vectors plus directed multi-cycle sequences for tetris_ctrl.
module tb_tetris_ctrl;
   import tetris_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  btn = '0;
   logic        uv = 1'b0;
   logic [7:0]  ud = '0;
   state_type   gs = INIT;
   logic [15:0] sc = '0;
   state_type   ctrl, ctrl_b;
   logic [9:0]  mask, mask_b;
   int          passed = 0;
   int          total = 0;

   always #5 clk = ~clk;

   tetris_ctrl #(
      .GRAVITY_BASE(20), .GRAVITY_STEP(4), .GRAVITY_MIN(8),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .BAR_PERIOD(0)
   ) dut (
      .clk(clk), .reset(rst), .btn(btn), .uart_valid(uv), .uart_data(ud),
      .game_state(gs), .score(sc), .ctrl(ctrl), .bar_mask(mask)
   );

   tetris_ctrl #(
      .GRAVITY_BASE(5), .GRAVITY_STEP(1), .GRAVITY_MIN(5),
      .REPEAT_DELAY(10), .REPEAT_PERIOD(4), .BAR_PERIOD(5)
   ) dut_b (
      .clk(clk), .reset(rst), .btn(btn), .uart_valid(uv), .uart_data(ud),
      .game_state(gs), .score(sc), .ctrl(ctrl_b), .bar_mask(mask_b)
   );

   typedef struct {
      logic      r;
      logic      v;
      logic [7:0] d;
      state_type g;
      state_type e;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t mk(input logic r, input logic v, input logic [7:0] d, input state_type g, input state_type e);
      vec_t x;
      x.r = r; x.v = v; x.d = d; x.g = g; x.e = e;
      return x;
   endfunction

   task automatic drive(input logic r, input logic [3:0] b, input logic v, input logic [7:0] d, input state_type g, input logic [15:0] s);
      @(negedge clk);
      rst = r; btn = b; uv = v; ud = d; gs = g; sc = s;
      #1;
   endtask

   task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s[%0d]: got %0h, expected %0h", name, k, got, exp);
   endtask

   task automatic grav_run(input logic [15:0] s, input int p);
      state_type e;
      drive(1, 0, 0, 0, INIT, s);
      for (int k = 0; k <= 2 * p; k++) begin
         drive(0, 0, 0, 0, WAIT, s);
         e = (k > 0 && k % p == 0) ? DOWN : NONE;
         chk("gravity", k, ctrl, e);
      end
   endtask

   initial begin
      state_type e;
      int lefts;
      // reset state
      drive(1, 0, 0, 0, INIT, 0);
      drive(1, 0, 0, 0, INIT, 0);
      chk("reset_ctrl", 0, ctrl, NONE);
      chk("reset_mask", 0, mask, 10'h3FD);
      chk("reset_mask_b", 0, mask_b, 10'h3FD);

      tbl.push_back(mk(0, 1, "s", INIT, NONE));
      tbl.push_back(mk(0, 0, 0,   INIT, DOWN));
      tbl.push_back(mk(0, 0, 0,   INIT, NONE));
      tbl.push_back(mk(0, 1, "a", WAIT, NONE));
      tbl.push_back(mk(0, 1, "d", WAIT, LEFT));
      tbl.push_back(mk(0, 1, "w", WAIT, RIGHT));
      tbl.push_back(mk(0, 1, "q", WAIT, ROTATE));
      tbl.push_back(mk(0, 1, " ", WAIT, ROTATE_REV));
      tbl.push_back(mk(0, 1, "x", WAIT, DROP));
      tbl.push_back(mk(0, 1, "c", WAIT, NONE));
      tbl.push_back(mk(0, 0, 0,   WAIT, HOLD));
      tbl.push_back(mk(0, 0, 0,   WAIT, NONE));
      tbl.push_back(mk(0, 1, "a", MOVE, NONE));
      tbl.push_back(mk(0, 0, 0,   MOVE, NONE));
      tbl.push_back(mk(0, 0, 0,   WAIT, LEFT));
      tbl.push_back(mk(0, 1, "s", END,  NONE));
      tbl.push_back(mk(0, 0, 0,   END,  DOWN));
      tbl.push_back(mk(0, 0, 0,   END,  NONE));
      tbl.push_back(mk(1, 1, "a", INIT, NONE));
      tbl.push_back(mk(0, 1, "a", MOVE, NONE));
      tbl.push_back(mk(0, 1, "d", MOVE, NONE));
      tbl.push_back(mk(0, 1, "w", MOVE, NONE));
      tbl.push_back(mk(0, 1, "q", MOVE, NONE));
      tbl.push_back(mk(0, 1, " ", MOVE, NONE));
      tbl.push_back(mk(0, 0, 0,   WAIT, LEFT));
      tbl.push_back(mk(0, 0, 0,   WAIT, RIGHT));
      tbl.push_back(mk(0, 0, 0,   WAIT, ROTATE));
      tbl.push_back(mk(0, 0, 0,   WAIT, ROTATE_REV));
      tbl.push_back(mk(0, 0, 0,   WAIT, NONE));
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, 0, tbl[i].v, tbl[i].d, tbl[i].g, 0);
         chk("vec_ctrl", i, ctrl, tbl[i].e);
         chk("vec_mask", i, mask, 10'h3FD);
      end

      // gravity period vs level, including clamp and underflow
      grav_run(16'h0020, 12);
      grav_run(16'h0002, 20);
      grav_run(16'h0040, 8);
      grav_run(16'h0100, 8);

      // held LEFT: initial press plus one auto-repeat
      drive(1, 0, 0, 0, INIT, 0);
      lefts = 0;
      for (int k = 0; k < 25; k++) begin
         drive(0, (k <= 10) ? 4'b0001 : 4'b0000, 0, 0, WAIT, 0);
         e = (k == 2 || k == 12) ? LEFT : (k == 20) ? DOWN : NONE;
         chk("btn_repeat", k, ctrl, e);
         if (ctrl == LEFT) lefts++;
      end
      chk("btn_left_count", 0, lefts, 2);

      // simultaneous buttons drain lowest index first
      drive(1, 0, 0, 0, INIT, 0);
      for (int k = 0; k < 6; k++) begin
         drive(0, (k < 2) ? 4'b1010 : 4'b0000, 0, 0, WAIT, 0);
         e = (k == 2) ? RIGHT : (k == 3) ? DOWN : NONE;
         chk("btn_order", k, ctrl, e);
      end

      // bar beats gravity beats FIFO; mask follows LFSR
      drive(1, 0, 0, 0, INIT, 0);
      for (int k = 0; k < 14; k++) begin
         drive(0, 0, k == 0, "a", (k < 5) ? MOVE : WAIT, 0);
         e = (k == 5 || k == 10) ? BAR : (k == 6 || k == 11) ? DOWN : (k == 7) ? LEFT : NONE;
         chk("bar_prio", k, ctrl_b, e);
         if (k == 5) chk("bar_mask0", k, mask_b, 10'h3FD);
         if (k == 8) chk("bar_mask1", k, mask_b, 10'h3FB);
         if (k == 13) chk("bar_mask2", k, mask_b, 10'h3EF);
      end

      // reset with queued keys and pending gravity
      drive(1, 0, 0, 0, INIT, 16'h0100);
      for (int k = 0; k < 8; k++) drive(0, 0, k < 3, (k == 0) ? "a" : (k == 1) ? "d" : "w", MOVE, 16'h0100);
      drive(1, 0, 1, "d", WAIT, 16'h0100);
      chk("midreset_ctrl", 0, ctrl, NONE);
      for (int k = 1; k < 4; k++) begin
         drive(0, 0, 0, 0, WAIT, 16'h0100);
         chk("midreset_ctrl", k, ctrl, NONE);
      end
      chk("midreset_mask", 0, mask, 10'h3FD);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
